// File: rtl/hdc_assoc_search.sv
// Associative-memory search stage.
// Buffers one query hypervector (NUM_FRAMES frames of FRAME_W bits). It then
// walks every (class, frame) address of the class hypervector generator, one
// frame per cycle, and accumulates the Hamming distance per class. The class
// with the smallest distance is reported; on a tie the lowest class id wins.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   query_frame      query frame data; query_valid/query_ready handshake
//   cv_frame_id      class address to the generator
//   cv_frame_index   frame address to the generator
//   class_vec_in     generator data for the current address (same cycle)
//   busy             high while searching or holding a result
//   result_valid     result handshake, with result_ready
//   best_class       winning class id
//   best_dist        winning Hamming distance
module hdc_assoc_search #(
  parameter int unsigned FRAME_W     = 64,
  parameter int unsigned NUM_FRAMES  = 3,
  parameter int unsigned NUM_CLASSES = 8,
  parameter int unsigned CLASS_W     = 3,
  parameter int unsigned FIDX_W      = 2,
  parameter int unsigned DIST_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] query_frame,
  input  logic               query_valid,
  output logic               query_ready,
  output logic [CLASS_W-1:0] cv_frame_id,
  output logic [FIDX_W-1:0]  cv_frame_index,
  input  logic [FRAME_W-1:0] class_vec_in,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [CLASS_W-1:0] best_class,
  output logic [DIST_W-1:0]  best_dist
);

  localparam logic [FIDX_W-1:0]  LastFrame = FIDX_W'(NUM_FRAMES - 1);
  localparam logic [CLASS_W-1:0] LastClass = CLASS_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {StLoad, StSearch, StDone} state_e;

  state_e             state_q;
  logic [FIDX_W-1:0]  lcnt_q;
  logic [FRAME_W-1:0] query_buf_q [NUM_FRAMES];
  logic [DIST_W-1:0]  acc_q;
  logic [DIST_W-1:0]  min_dist_q;
  logic [CLASS_W-1:0] min_class_q;

  logic               frame_accept;
  logic [FRAME_W-1:0] diff;
  logic [DIST_W-1:0]  frame_dist;
  logic [DIST_W-1:0]  total;
  logic               new_min;
  logic [DIST_W-1:0]  win_dist;
  logic [CLASS_W-1:0] win_class;

  assign frame_accept = query_valid & query_ready;

  // Distance of the current frame and the running-minimum update that would
  // apply if this is the last frame of the class.
  always_comb begin
    diff       = query_buf_q[cv_frame_index] ^ class_vec_in;
    frame_dist = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      frame_dist = frame_dist + DIST_W'(diff[i]);
    end
    total     = acc_q + frame_dist;
    // Strict compare keeps the earlier (lower) class id on a tie.
    new_min   = total < min_dist_q;
    win_dist  = new_min ? total : min_dist_q;
    win_class = new_min ? cv_frame_id : min_class_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StLoad;
      lcnt_q         <= '0;
      acc_q          <= '0;
      min_dist_q     <= '0;
      min_class_q    <= '0;
      query_ready    <= 1'b0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      best_class     <= '0;
      best_dist      <= '0;
      cv_frame_id    <= '0;
      cv_frame_index <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          query_ready <= 1'b1;
          if (frame_accept) begin
            query_buf_q[lcnt_q] <= query_frame;
            lcnt_q              <= lcnt_q + 1'b1;
            if (lcnt_q == LastFrame) begin
              query_ready    <= 1'b0;
              busy           <= 1'b1;
              state_q        <= StSearch;
              cv_frame_id    <= '0;
              cv_frame_index <= '0;
              acc_q          <= '0;
              min_dist_q     <= '1;
              min_class_q    <= '0;
            end
          end
        end
        StSearch: begin
          if (cv_frame_index == LastFrame) begin
            min_dist_q     <= win_dist;
            min_class_q    <= win_class;
            acc_q          <= '0;
            cv_frame_index <= '0;
            if (cv_frame_id == LastClass) begin
              cv_frame_id  <= '0;
              best_class   <= win_class;
              best_dist    <= win_dist;
              result_valid <= 1'b1;
              state_q      <= StDone;
            end else begin
              cv_frame_id <= cv_frame_id + 1'b1;
            end
          end else begin
            acc_q          <= total;
            cv_frame_index <= cv_frame_index + 1'b1;
          end
        end
        StDone: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            query_ready  <= 1'b1;
            lcnt_q       <= '0;
            state_q      <= StLoad;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_hdc_assoc_search.sv
// Bench for hdc_assoc_search: directed queries against a stub generator.
// The compare process holds a protocol-level model (expected phase and search
// step per cycle) and an argmin-of-Hamming-distance reference result.
module tb_hdc_assoc_search;

  localparam int FW = 64;
  localparam int NF = 3;
  localparam int NC = 8;
  localparam logic [FW-1:0] ONES  = {FW{1'b1}};
  localparam logic [FW-1:0] ZEROS = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] query_frame = '0;
  logic          query_valid = 1'b0;
  logic          query_ready;
  logic [2:0]    cv_frame_id;
  logic [1:0]    cv_frame_index;
  logic [FW-1:0] class_vec_in;
  logic          busy;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [2:0]    best_class;
  logic [7:0]    best_dist;

  int mode = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hdc_assoc_search dut (
    .clk            (clk),
    .rst            (rst),
    .query_frame    (query_frame),
    .query_valid    (query_valid),
    .query_ready    (query_ready),
    .cv_frame_id    (cv_frame_id),
    .cv_frame_index (cv_frame_index),
    .class_vec_in   (class_vec_in),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .best_class     (best_class),
    .best_dist      (best_dist)
  );

  function automatic logic [FW-1:0] nones(input int n);
    logic [FW-1:0] one = 1;
    return (one << n) - one;
  endfunction

  // Stub generator patterns.
  function automatic logic [FW-1:0] gen_frame(input int m, input int c, input int f);
    logic [FW-1:0] h;
    case (m)
      0: return (c == 5) ? ZEROS : ONES;
      1: return ZEROS;
      2: return (f == 0) ? nones(10 + c) : ZEROS;
      3: return (f == 0) ? nones(20 - c) : ZEROS;
      default: begin
        h = 64'h9E3779B97F4A7C15 * 64'(c * NF + f + 1);
        return h ^ (h >> 17);
      end
    endcase
  endfunction

  always_comb class_vec_in = gen_frame(mode, int'(cv_frame_id), int'(cv_frame_index));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + compare process ----------------
  localparam int MUnknown = 0, MRst = 1, MLoad = 2, MSearch = 3, MDone = 4;
  int            mstate = MUnknown;
  int            mstep;
  int            mlcnt;
  int            exp_cls;
  int            exp_dst;
  logic [FW-1:0] mbuf [NF];

  task automatic model_result();
    int best = 1 << 30;
    int bc = 0;
    for (int c = 0; c < NC; c++) begin
      int d = 0;
      for (int f = 0; f < NF; f++) d += $countones(mbuf[f] ^ gen_frame(mode, c, f));
      if (d < best) begin
        best = d;
        bc   = c;
      end
    end
    exp_cls = bc;
    exp_dst = best;
  endtask

  always @(negedge clk) begin
    case (mstate)
      MRst: begin
        check("rst_query_ready", query_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_best_class", best_class, 0);
        check("rst_best_dist", best_dist, 0);
        check("rst_frame_id", cv_frame_id, 0);
        check("rst_frame_index", cv_frame_index, 0);
      end
      MLoad: begin
        check("load_query_ready", query_ready, 1);
        check("load_busy", busy, 0);
        check("load_result_valid", result_valid, 0);
      end
      MSearch: begin
        check("search_query_ready", query_ready, 0);
        check("search_busy", busy, 1);
        check("search_result_valid", result_valid, 0);
        check("search_frame_id", cv_frame_id, mstep / NF);
        check("search_frame_index", cv_frame_index, mstep % NF);
      end
      MDone: begin
        check("done_query_ready", query_ready, 0);
        check("done_busy", busy, 1);
        check("done_result_valid", result_valid, 1);
        check("done_best_class", best_class, exp_cls);
        check("done_best_dist", best_dist, exp_dst);
      end
      default: ;
    endcase
    // Next-cycle expectation from the inputs the coming edge will sample.
    if (rst) begin
      mstate = MRst;
      mlcnt  = 0;
    end else begin
      case (mstate)
        MRst: mstate = MLoad;
        MLoad: if (query_valid) begin
          mbuf[mlcnt] = query_frame;
          mlcnt++;
          if (mlcnt == NF) begin
            model_result();
            mstate = MSearch;
            mstep  = 0;
          end
        end
        MSearch: begin
          mstep++;
          if (mstep == NF * NC) mstate = MDone;
        end
        MDone: if (result_ready) begin
          mstate = MLoad;
          mlcnt  = 0;
        end
        default: ;
      endcase
    end
  end

  // ---------------- driver ----------------
  task automatic load_query(input int m, input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                            input logic [FW-1:0] f2);
    logic [FW-1:0] fr [NF];
    fr[0] = f0;
    fr[1] = f1;
    fr[2] = f2;
    mode = m;
    for (int k = 0; k < NF; k++) begin
      int t = 0;
      while (!query_ready && t < 50) begin
        @(posedge clk);
        #1;
        t++;
      end
      check("query_ready_wait", query_ready, 1);
      query_valid = 1'b1;
      query_frame = fr[k];
      @(posedge clk);
      #1;
    end
    query_valid = 1'b0;
  endtask

  // Called right after the edge that accepted the last frame.
  task automatic wait_result(input int ec, input int ed);
    int t = 0;
    while (!result_valid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("result_latency", t, NF * NC);
    check("lit_best_class", best_class, ec);
    check("lit_best_dist", best_dist, ed);
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check("release_query_ready", query_ready, 1);
    check("release_result_valid", result_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("lit_reset_query_ready", query_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("lit_ready_after_reset", query_ready, 1);

    // Only class 5 matches an all-zero query.
    load_query(0, ZEROS, ZEROS, ZEROS);
    wait_result(5, 0);
    release_result();

    // Every class is equally far; lowest id wins.
    load_query(1, ONES, ONES, ONES);
    wait_result(0, 192);
    release_result();

    // Class k has 10+k ones, then 20-k ones.
    load_query(2, ZEROS, ZEROS, ZEROS);
    wait_result(0, 10);
    release_result();
    load_query(3, ZEROS, ZEROS, ZEROS);
    wait_result(7, 13);
    release_result();

    // Backpressure on a pseudo-random pattern, stray query_valid pulses ignored.
    load_query(4, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h00FF00FF0F0F0F0F);
    begin
      int t = 0;
      while (!result_valid && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
      check("bp_latency", t, NF * NC);
    end
    for (int i = 0; i < 10; i++) begin
      query_valid = i[0];
      query_frame = ONES;
      @(posedge clk);
      #1;
      check("bp_query_ready", query_ready, 0);
    end
    query_valid = 1'b0;
    release_result();

    // Second query after backpressure: all-ones query, class 5 is the far one.
    load_query(0, ONES, ONES, ONES);
    wait_result(0, 0);
    release_result();

    // Reset in the middle of a search.
    load_query(2, ONES, ONES, ONES);
    repeat (12) @(posedge clk);
    #1;
    check("lit_mid_search_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("lit_mid_rst_busy", busy, 0);
    check("lit_mid_rst_frame_id", cv_frame_id, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("lit_mid_rst_ready", query_ready, 1);
    load_query(2, ZEROS, ZEROS, ZEROS);
    wait_result(0, 10);
    release_result();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
